// File: rtl/move_event_gen_pkg.sv
// Shared definitions for the move event generator: direction encodings decoded
// by the game core, FSM state encoding and button classification helpers.
package move_event_gen_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        ST_ARMED_CHECK = 3'd0,
        ST_IDLE        = 3'd1,
        ST_HOLD        = 3'd2,
        ST_REPEAT      = 3'd3,
        ST_LOCKOUT     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_CHORD  = 2'd2
    } btn_class_e;

    // Buttons are packed as {right, left, down, up}.
    function automatic btn_class_e classify(input logic [3:0] btns);
        logic [2:0] n;
        btn_class_e cls;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, btns[i]};
        end
        case (n)
            3'd0:    cls = CLS_NONE;
            3'd1:    cls = CLS_SINGLE;
            default: cls = CLS_CHORD;
        endcase
        return cls;
    endfunction

    function automatic logic [1:0] encode_dir(input logic [3:0] btns);
        logic [1:0] dir;
        case (btns)
            4'b0001: dir = DIR_UP;
            4'b0010: dir = DIR_DOWN;
            4'b0100: dir = DIR_LEFT;
            4'b1000: dir = DIR_RIGHT;
            default: dir = DIR_UP;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/move_event_gen.sv
// Turns debounced direction-button levels into valid/ready move commands with
// optional auto-repeat; chords and buttons held through reset never produce moves.
module move_event_gen
    import move_event_gen_pkg::*;
#(
    parameter int HOLD_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CNT_W         = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       repeat_en,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir
);

    logic [3:0]       btns_s;
    btn_class_e       class_s;
    logic [1:0]       btn_dir_s;
    logic             same_s;
    logic             term_s;
    logic             issue_s;
    logic [1:0]       issue_dir_s;
    logic             accept_s;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       held_dir_q, held_dir_d;
    logic             valid_q,    valid_d;
    logic [1:0]       dir_q,      dir_d;

    // Classify the current button levels
    always_comb begin
        btns_s    = {btn_right, btn_left, btn_down, btn_up};
        class_s   = classify(btns_s);
        btn_dir_s = encode_dir(btns_s);
        same_s    = (class_s == CLS_SINGLE) && (btn_dir_s == held_dir_q);
        if (state_q == ST_HOLD) begin
            term_s = (cnt_q == CNT_W'(HOLD_DELAY - 1));
        end else begin
            term_s = (cnt_q == CNT_W'(REPEAT_PERIOD - 1));
        end
    end

    // Next-state, counter and issue decision
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        held_dir_d  = held_dir_q;
        issue_s     = 1'b0;
        issue_dir_s = held_dir_q;
        case (state_q)
            ST_ARMED_CHECK: begin
                cnt_d = {CNT_W{1'b0}};
                if (class_s == CLS_NONE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKOUT;
                end
            end
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (class_s == CLS_SINGLE) begin
                    issue_s     = 1'b1;
                    issue_dir_s = btn_dir_s;
                    held_dir_d  = btn_dir_s;
                    state_d     = ST_HOLD;
                end else if (class_s == CLS_CHORD) begin
                    state_d = ST_LOCKOUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (class_s == CLS_NONE) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                end else if (same_s) begin
                    if (term_s) begin
                        // repeat_en only gates the move; timing advances regardless
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_REPEAT;
                        issue_s = repeat_en;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                cnt_d = {CNT_W{1'b0}};
                if (class_s == CLS_NONE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKOUT;
                end
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_ARMED_CHECK;
            end
        endcase
    end

    // Output register update: load, retire on transfer, or hold
    always_comb begin
        accept_s = !valid_q || move_ready;
        valid_d  = valid_q;
        dir_d    = dir_q;
        if (issue_s && accept_s) begin
            valid_d = 1'b1;
            dir_d   = issue_dir_s;
        end else if (valid_q && move_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // FSM, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARMED_CHECK;
            cnt_q      <= {CNT_W{1'b0}};
            held_dir_q <= DIR_UP;
            valid_q    <= 1'b0;
            dir_q      <= DIR_UP;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            held_dir_q <= held_dir_d;
            valid_q    <= valid_d;
            dir_q      <= dir_d;
        end
    end

    assign move_valid = valid_q;
    assign move_dir   = dir_q;

endmodule

// File: tb/tb_move_event_gen.sv
// Directed self-checking bench for move_event_gen with short hold/repeat periods.
module tb_move_event_gen;

    localparam int HD = 8;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       repeat_en, move_ready;
    logic       move_valid;
    logic [1:0] move_dir;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         p;
    int         xfer_cyc[$];
    logic [1:0] xfer_dir[$];

    move_event_gen #(
        .HOLD_DELAY    (HD),
        .REPEAT_PERIOD (RP),
        .CNT_W         (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .repeat_en  (repeat_en),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move_dir   (move_dir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change just after posedge, so a negedge sample predicts the next edge
    always @(negedge clk) begin
        if (!rst && move_valid && move_ready) begin
            xfer_cyc.push_back(cyc);
            xfer_dir.push_back(move_dir);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    endtask

    task automatic clear_log();
        xfer_cyc.delete();
        xfer_dir.delete();
    endtask

    initial begin
        rst = 1'b1; repeat_en = 1'b1; move_ready = 1'b1;
        set_btn(1'b0, 1'b0, 1'b1, 1'b0);

        // 1: left held through reset never moves
        step(2);
        check_val("rst_valid", move_valid, 0);
        check_val("rst_dir", move_dir, 0);
        rst = 1'b0;
        clear_log();
        step(20);
        check_val("t1_hold_moves", xfer_cyc.size(), 0);
        check_val("t1_hold_valid", move_valid, 0);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        p = cyc;
        set_btn(1'b0, 1'b0, 1'b1, 1'b0);
        step(3);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        step(3);
        check_val("t1_moves", xfer_cyc.size(), 1);
        if (xfer_cyc.size() == 1) begin
            check_val("t1_dir", xfer_dir[0], 2);
            check_val("t1_lat", xfer_cyc[0] - p, 1);
        end

        // 2: 3-cycle up pulse
        clear_log();
        p = cyc;
        set_btn(1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        check_val("t2_valid_hi", move_valid, 1);
        check_val("t2_dir", move_dir, 0);
        step(1);
        check_val("t2_valid_lo", move_valid, 0);
        step(1);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        step(3);
        check_val("t2_moves", xfer_cyc.size(), 1);

        // 3: right held through four classifications of repeat, released before the fifth
        clear_log();
        p = cyc;
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        step(19);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        step(3);
        check_val("t3_moves", xfer_cyc.size(), 4);
        if (xfer_cyc.size() == 4) begin
            check_val("t3_off0", xfer_cyc[0] - p, 1);
            check_val("t3_off1", xfer_cyc[1] - p, 9);
            check_val("t3_off2", xfer_cyc[2] - p, 13);
            check_val("t3_off3", xfer_cyc[3] - p, 17);
            for (int i = 0; i < 4; i++) check_val("t3_dir", xfer_dir[i], 3);
        end
        repeat_en = 1'b0;
        clear_log();
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        step(19);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        step(3);
        check_val("t3_norep_moves", xfer_cyc.size(), 1);
        repeat_en = 1'b1;

        // 4: down held with ready low; repeats dropped
        clear_log();
        move_ready = 1'b0;
        set_btn(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step(1);
            check_val("t4_valid", move_valid, 1);
            check_val("t4_dir", move_dir, 1);
        end
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_val("t4_pending", move_valid, 1);
        check_val("t4_no_xfer", xfer_cyc.size(), 0);
        move_ready = 1'b1;
        step(3);
        check_val("t4_moves", xfer_cyc.size(), 1);
        if (xfer_cyc.size() == 1) check_val("t4_xdir", xfer_dir[0], 1);
        check_val("t4_valid_lo", move_valid, 0);

        // 5: chord lockout, then a clean left press
        clear_log();
        set_btn(1'b1, 1'b0, 1'b0, 1'b0);
        step(3);
        set_btn(1'b1, 1'b0, 1'b1, 1'b0);
        step(12);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check_val("t5_chord_moves", xfer_cyc.size(), 1);
        if (xfer_cyc.size() == 1) check_val("t5_chord_dir", xfer_dir[0], 0);
        p = cyc;
        set_btn(1'b0, 1'b0, 1'b1, 1'b0);
        step(2);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        step(3);
        check_val("t5_moves", xfer_cyc.size(), 2);
        if (xfer_cyc.size() == 2) begin
            check_val("t5_dir", xfer_dir[1], 2);
            check_val("t5_lat", xfer_cyc[1] - p, 1);
        end

        // 6: reset aborts a pending move
        clear_log();
        move_ready = 1'b0;
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        step(2);
        check_val("t6_pend_valid", move_valid, 1);
        check_val("t6_pend_dir", move_dir, 3);
        rst = 1'b1;
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        check_val("t6_rst_valid", move_valid, 0);
        check_val("t6_rst_dir", move_dir, 0);
        rst = 1'b0;
        move_ready = 1'b1;
        step(2);
        check_val("t6_after_valid", move_valid, 0);
        check_val("t6_no_xfer", xfer_cyc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
